// File: rtl/dp_ram_pkg.sv
// Shared types and default parameter values for the dual-port RAM block.
package dp_ram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam int unsigned DEF_DATA_W = 8;
   localparam int unsigned DEF_ADDR_W = 12;
   localparam int unsigned DEF_RD_LAT = 1;

endpackage

// File: rtl/dp_ram_core.sv
// Byte-enabled storage array: one write port, one registered read port.
// The array has no reset; only the read register is cleared.
module dp_ram_core
   import dp_ram_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                we,
   input  logic [ADDR_W-1:0]   waddr,
   input  logic [DATA_W-1:0]   wdata,
   input  logic [DATA_W/8-1:0] wbe,
   input  logic                re,
   input  logic [ADDR_W-1:0]   raddr,
   output logic [DATA_W-1:0]   rdata
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned i = 0; i < NB; i++) begin
            if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Read-first: a same-cycle write is not visible here.
   always_ff @(posedge clk) begin
      if (rst)     rdata <= '0;
      else if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/dp_ram.sv
// Dual-port RAM with power-up clear sequence, 1- or 2-cycle read latency.
// Define DP_RAM_BYPASS_EN for write-first same-address collisions (read-first otherwise).
module dp_ram
   import dp_ram_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned RD_LAT = DEF_RD_LAT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [DATA_W/8-1:0] wr_be,
   input  logic                rd_en,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [DATA_W-1:0]   rd_data,
   output logic                rd_valid,
   output logic                busy
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              clearing;
   logic              ready;
   logic              rd_issue;
   logic              core_we;
   logic [ADDR_W-1:0] core_waddr;
   logic [DATA_W-1:0] core_wdata;
   logic [DATA_W/8-1:0] core_wbe;
   logic [DATA_W-1:0] core_rdata;
   logic [DATA_W-1:0] stage1;
   logic              v1_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_CLEAR;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         ST_CLEAR: begin
            if (ptr_q == '1) state_d = ST_READY;
            else             ptr_d   = ptr_q + ADDR_W'(1);
         end
         ST_READY: ;
         default: begin
            state_d = ST_CLEAR;
            ptr_d   = '0;
         end
      endcase
   end

   assign clearing = (state_q == ST_CLEAR);
   assign ready    = (state_q == ST_READY);
   assign busy     = clearing;
   assign rd_issue = rd_en && ready && !rst;

   // The clear sequence owns the write port; user writes only land when ready.
   always_comb begin
      core_we    = !rst && (clearing || (wr_en && ready));
      core_waddr = clearing ? ptr_q : wr_addr;
      core_wdata = clearing ? '0 : wr_data;
      core_wbe   = clearing ? '1 : wr_be;
   end

   dp_ram_core #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_core (
      .clk   (clk),
      .rst   (rst),
      .we    (core_we),
      .waddr (core_waddr),
      .wdata (core_wdata),
      .wbe   (core_wbe),
      .re    (rd_issue),
      .raddr (rd_addr),
      .rdata (core_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) v1_q <= 1'b0;
      else     v1_q <= rd_issue;
   end

`ifdef DP_RAM_BYPASS_EN
   localparam int unsigned NB = DATA_W / 8;

   logic              hit_q;
   logic [DATA_W-1:0] byp_data_q;
   logic [NB-1:0]     byp_be_q;

   // Capture the colliding write alongside the read; merge onto the old word next cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         hit_q      <= 1'b0;
         byp_data_q <= '0;
         byp_be_q   <= '0;
      end else if (rd_issue) begin
         hit_q      <= wr_en && (wr_addr == rd_addr);
         byp_data_q <= wr_data;
         byp_be_q   <= wr_be;
      end
   end

   always_comb begin
      stage1 = core_rdata;
      for (int unsigned i = 0; i < NB; i++) begin
         if (hit_q && byp_be_q[i]) stage1[8*i +: 8] = byp_data_q[8*i +: 8];
      end
   end
`else
   always_comb stage1 = core_rdata;
`endif

   if (RD_LAT == 2) begin : g_lat2
      logic              v2_q;
      logic [DATA_W-1:0] d2_q;

      always_ff @(posedge clk) begin
         if (rst) begin
            v2_q <= 1'b0;
            d2_q <= '0;
         end else begin
            v2_q <= v1_q;
            if (v1_q) d2_q <= stage1;
         end
      end

      assign rd_valid = v2_q;
      assign rd_data  = d2_q;
   end else begin : g_lat1
      assign rd_valid = v1_q;
      assign rd_data  = stage1;
   end

endmodule

// File: tb/tb_dp_ram.sv
// Directed self-checking bench: a 16-bit/latency-1 instance and an 8-bit/latency-2 instance.
module tb_dp_ram;

   logic        clk;

   logic        a_rst, a_wr_en, a_rd_en;
   logic [3:0]  a_wr_addr, a_rd_addr;
   logic [15:0] a_wr_data;
   logic [1:0]  a_wr_be;
   logic [15:0] a_rd_data;
   logic        a_rd_valid, a_busy;

   logic        b_rst, b_wr_en, b_rd_en;
   logic [3:0]  b_wr_addr, b_rd_addr;
   logic [7:0]  b_wr_data;
   logic [0:0]  b_wr_be;
   logic [7:0]  b_rd_data;
   logic        b_rd_valid, b_busy;

   int n_cmp = 0;
   int n_bad = 0;

   dp_ram #(.DATA_W(16), .ADDR_W(4), .RD_LAT(1)) u_dut_a (
      .clk(clk), .rst(a_rst), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
      .wr_data(a_wr_data), .wr_be(a_wr_be), .rd_en(a_rd_en), .rd_addr(a_rd_addr),
      .rd_data(a_rd_data), .rd_valid(a_rd_valid), .busy(a_busy)
   );

   dp_ram #(.DATA_W(8), .ADDR_W(4), .RD_LAT(2)) u_dut_b (
      .clk(clk), .rst(b_rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
      .wr_data(b_wr_data), .wr_be(b_wr_be), .rd_en(b_rd_en), .rd_addr(b_rd_addr),
      .rd_data(b_rd_data), .rd_valid(b_rd_valid), .busy(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic a_write(input logic [3:0] addr, input logic [15:0] data, input logic [1:0] be);
      a_wr_en = 1'b1; a_wr_addr = addr; a_wr_data = data; a_wr_be = be;
      tick();
      a_wr_en = 1'b0;
   endtask

   task automatic a_read(input logic [3:0] addr, output logic v, output logic [15:0] d);
      a_rd_en = 1'b1; a_rd_addr = addr;
      tick();
      a_rd_en = 1'b0;
      v = a_rd_valid; d = a_rd_data;
   endtask

   // Counts busy cycles from the reset edge (already 1) until busy drops; flags any rd_valid.
   task automatic a_count_busy(output int cnt, output logic saw_valid);
      int guard = 0;
      cnt = 1; saw_valid = 1'b0;
      while (a_busy === 1'b1 && guard < 200) begin
         tick();
         guard++;
         if (a_rd_valid !== 1'b0) saw_valid = 1'b1;
         if (a_busy === 1'b1) cnt++;
      end
   endtask

   task automatic b_count_busy(output int cnt, output logic saw_valid);
      int guard = 0;
      cnt = 1; saw_valid = 1'b0;
      while (b_busy === 1'b1 && guard < 200) begin
         tick();
         guard++;
         if (b_rd_valid !== 1'b0) saw_valid = 1'b1;
         if (b_busy === 1'b1) cnt++;
      end
   endtask

   task automatic test_reset();
      a_rst = 1'b1;
      tick();
      a_rst = 1'b0;
      n_cmp++;
      if (a_busy !== 1'b1 || a_rd_valid !== 1'b0 || a_rd_data !== 16'h0000) begin
         n_bad++;
         $display("FAIL reset_state: busy=%b valid=%b data=%h, want busy=1 valid=0 data=0000",
                  a_busy, a_rd_valid, a_rd_data);
      end
   endtask

   task automatic test_clear_access();
      int cnt; logic saw;
      a_wr_en = 1'b1; a_wr_addr = 4'd3; a_wr_data = 16'hFFFF; a_wr_be = 2'b11;
      a_rd_en = 1'b1; a_rd_addr = 4'd3;
      a_count_busy(cnt, saw);
      a_wr_en = 1'b0; a_rd_en = 1'b0;
      n_cmp++;
      if (cnt !== 16) begin
         n_bad++;
         $display("FAIL clear_busy_len: got %0d cycles, want 16", cnt);
      end
      n_cmp++;
      if (saw !== 1'b0) begin
         n_bad++;
         $display("FAIL clear_no_valid: rd_valid pulsed during clear, want none");
      end
   endtask

   task automatic test_clear_readback();
      for (int i = 0; i < 16; i++) begin
         a_rd_en = 1'b1; a_rd_addr = 4'(i);
         tick();
         n_cmp++;
         if (a_rd_valid !== 1'b1 || a_rd_data !== 16'h0000) begin
            n_bad++;
            $display("FAIL clear_read[%0d]: valid=%b data=%h, want valid=1 data=0000",
                     i, a_rd_valid, a_rd_data);
         end
      end
      a_rd_en = 1'b0;
   endtask

   task automatic test_write_readback();
      logic [15:0] exp [3];
      exp[0] = 16'h0001; exp[1] = 16'h0002; exp[2] = 16'h0003;
      for (int i = 0; i < 3; i++) a_write(4'(i), exp[i], 2'b11);
      for (int i = 0; i < 3; i++) begin
         a_rd_en = 1'b1; a_rd_addr = 4'(i);
         tick();
         n_cmp++;
         if (a_rd_valid !== 1'b1 || a_rd_data !== exp[i]) begin
            n_bad++;
            $display("FAIL b2b_read[%0d]: valid=%b data=%h, want valid=1 data=%h",
                     i, a_rd_valid, a_rd_data, exp[i]);
         end
      end
      a_rd_en = 1'b0;
      tick();
      n_cmp++;
      if (a_rd_valid !== 1'b0 || a_rd_data !== 16'h0003) begin
         n_bad++;
         $display("FAIL read_hold: valid=%b data=%h, want valid=0 data=0003", a_rd_valid, a_rd_data);
      end
   endtask

   task automatic test_byte_enable();
      logic v; logic [15:0] d;
      a_write(4'd7, 16'hAABB, 2'b11);
      a_write(4'd7, 16'h1234, 2'b01);
      a_read(4'd7, v, d);
      n_cmp++;
      if (v !== 1'b1 || d !== 16'hAA34) begin
         n_bad++;
         $display("FAIL be_low: valid=%b data=%h, want valid=1 data=aa34", v, d);
      end
      a_write(4'd7, 16'hFFFF, 2'b00);
      a_read(4'd7, v, d);
      n_cmp++;
      if (d !== 16'hAA34) begin
         n_bad++;
         $display("FAIL be_none: data=%h, want aa34", d);
      end
      a_write(4'd7, 16'h5600, 2'b10);
      a_read(4'd7, v, d);
      n_cmp++;
      if (d !== 16'h5634) begin
         n_bad++;
         $display("FAIL be_high: data=%h, want 5634", d);
      end
   endtask

   task automatic test_collision();
      logic v; logic [15:0] d;
      logic [15:0] exp_full, exp_part;
`ifdef DP_RAM_BYPASS_EN
      exp_full = 16'h0022; exp_part = 16'h1122;
`else
      exp_full = 16'h0011; exp_part = 16'h1111;
`endif
      a_write(4'd5, 16'h0011, 2'b11);
      a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 16'h0022; a_wr_be = 2'b11;
      a_read(4'd5, v, d);
      a_wr_en = 1'b0;
      n_cmp++;
      if (v !== 1'b1 || d !== exp_full) begin
         n_bad++;
         $display("FAIL collide_full: valid=%b data=%h, want valid=1 data=%h", v, d, exp_full);
      end
      a_read(4'd5, v, d);
      n_cmp++;
      if (d !== 16'h0022) begin
         n_bad++;
         $display("FAIL collide_after: data=%h, want 0022", d);
      end
      a_write(4'd5, 16'h1111, 2'b11);
      a_wr_en = 1'b1; a_wr_addr = 4'd5; a_wr_data = 16'h2222; a_wr_be = 2'b01;
      a_read(4'd5, v, d);
      a_wr_en = 1'b0;
      n_cmp++;
      if (d !== exp_part) begin
         n_bad++;
         $display("FAIL collide_part: data=%h, want %h", d, exp_part);
      end
      // Write elsewhere while reading: must not disturb the read.
      a_wr_en = 1'b1; a_wr_addr = 4'd6; a_wr_data = 16'h0066; a_wr_be = 2'b11;
      a_read(4'd5, v, d);
      a_wr_en = 1'b0;
      n_cmp++;
      if (d !== 16'h1122) begin
         n_bad++;
         $display("FAIL diff_addr_read: data=%h, want 1122", d);
      end
      a_read(4'd6, v, d);
      n_cmp++;
      if (d !== 16'h0066) begin
         n_bad++;
         $display("FAIL diff_addr_write: data=%h, want 0066", d);
      end
   endtask

   task automatic test_reclear();
      int cnt; logic saw; logic v; logic [15:0] d;
      logic [3:0] addrs [5];
      addrs[0] = 4'd0; addrs[1] = 4'd1; addrs[2] = 4'd2; addrs[3] = 4'd5; addrs[4] = 4'd7;
      a_rst = 1'b1; tick(); a_rst = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      a_rst = 1'b1; tick(); a_rst = 1'b0;
      a_count_busy(cnt, saw);
      n_cmp++;
      if (cnt !== 16) begin
         n_bad++;
         $display("FAIL reclear_busy_len: got %0d cycles, want 16", cnt);
      end
      for (int i = 0; i < 5; i++) begin
         a_read(addrs[i], v, d);
         n_cmp++;
         if (v !== 1'b1 || d !== 16'h0000) begin
            n_bad++;
            $display("FAIL reclear_read[%0d]: valid=%b data=%h, want valid=1 data=0000",
                     addrs[i], v, d);
         end
      end
   endtask

   task automatic test_lat2();
      int cnt; logic saw;
      b_rst = 1'b1; tick(); b_rst = 1'b0;
      b_count_busy(cnt, saw);
      n_cmp++;
      if (cnt !== 16 || saw !== 1'b0) begin
         n_bad++;
         $display("FAIL lat2_clear: busy %0d cycles valid_seen=%b, want 16 and 0", cnt, saw);
      end
      b_wr_en = 1'b1; b_wr_addr = 4'd9;  b_wr_data = 8'h5A; b_wr_be = 1'b1; tick();
      b_wr_addr = 4'd10; b_wr_data = 8'hA5; tick();
      b_wr_en = 1'b0;
      b_rd_en = 1'b1; b_rd_addr = 4'd9; tick();
      n_cmp++;
      if (b_rd_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL lat2_early: valid=%b one edge after issue, want 0", b_rd_valid);
      end
      b_rd_addr = 4'd10; tick();
      b_rd_en = 1'b0;
      n_cmp++;
      if (b_rd_valid !== 1'b1 || b_rd_data !== 8'h5A) begin
         n_bad++;
         $display("FAIL lat2_first: valid=%b data=%h, want valid=1 data=5a", b_rd_valid, b_rd_data);
      end
      tick();
      n_cmp++;
      if (b_rd_valid !== 1'b1 || b_rd_data !== 8'hA5) begin
         n_bad++;
         $display("FAIL lat2_second: valid=%b data=%h, want valid=1 data=a5", b_rd_valid, b_rd_data);
      end
      tick();
      n_cmp++;
      if (b_rd_valid !== 1'b0 || b_rd_data !== 8'hA5) begin
         n_bad++;
         $display("FAIL lat2_hold: valid=%b data=%h, want valid=0 data=a5", b_rd_valid, b_rd_data);
      end
   endtask

   task automatic test_reset_midop();
      int cnt; logic saw;
      b_rd_en = 1'b1; b_rd_addr = 4'd9; tick();
      b_rd_en = 1'b0; b_rst = 1'b1; tick();
      b_rst = 1'b0;
      n_cmp++;
      if (b_rd_valid !== 1'b0 || b_rd_data !== 8'h00 || b_busy !== 1'b1) begin
         n_bad++;
         $display("FAIL midop_reset: valid=%b data=%h busy=%b, want 0/00/1",
                  b_rd_valid, b_rd_data, b_busy);
      end
      b_count_busy(cnt, saw);
      n_cmp++;
      if (cnt !== 16 || saw !== 1'b0) begin
         n_bad++;
         $display("FAIL midop_clear: busy %0d cycles valid_seen=%b, want 16 and 0", cnt, saw);
      end
      b_rd_en = 1'b1; b_rd_addr = 4'd9; tick();
      b_rd_en = 1'b0; tick();
      n_cmp++;
      if (b_rd_valid !== 1'b1 || b_rd_data !== 8'h00) begin
         n_bad++;
         $display("FAIL midop_readback: valid=%b data=%h, want valid=1 data=00", b_rd_valid, b_rd_data);
      end
   endtask

   initial begin
      a_rst = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b0;
      a_wr_addr = '0; a_rd_addr = '0; a_wr_data = '0; a_wr_be = '0;
      b_rst = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0;
      b_wr_addr = '0; b_rd_addr = '0; b_wr_data = '0; b_wr_be = '0;
      tick();
      test_reset();
      test_clear_access();
      test_clear_readback();
      test_write_readback();
      test_byte_enable();
      test_collision();
      test_reclear();
      test_lat2();
      test_reset_midop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
